mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch vs. load/store) in front of one single-ported memory.
// Data side normally wins; a starvation counter hands priority to a waiting fetch after STARVE_MAX data wins.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_func,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_func,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;
  logic        drop_q, drop_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [2:0]  mem_func_q, mem_func_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        fetch_pri;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    drop_d      = drop_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_func_d  = mem_func_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    fetch_pri   = if_req && (starve_q == STARVE_LIM);

    case (state_q)
      IDLE: begin
        // Grants are combinational but suppressed while reset is asserted
        if (!rst) begin
          if (d_req && !fetch_pri) d_gnt = 1'b1;
          else if (if_req)         if_gnt = 1'b1;
        end
        if (d_gnt) begin
          state_d     = BUSY;
          owner_d     = 1'b1;
          drop_d      = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_func_d  = d_func;
          mem_wdata_d = d_wdata;
          if (!if_req)                       starve_d = 4'd0;
          else if (starve_q != STARVE_LIM)   starve_d = starve_q + 4'd1;
        end else if (if_gnt) begin
          state_d     = BUSY;
          owner_d     = 1'b0;
          drop_d      = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_func_d  = 3'b010;
          mem_wdata_d = 32'd0;
          starve_d    = 4'd0;
        end else if (!if_req) begin
          starve_d = 4'd0;
        end
      end

      BUSY: begin
        if (!owner_q && if_flush) drop_d = 1'b1;
        // A flush in the completion cycle itself must also kill the response
        if (mem_ready) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          drop_d   = 1'b0;
          if (owner_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_we_q ? 32'd0 : mem_rdata;
          end else if (!(drop_q || if_flush)) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      starve_q    <= 4'd0;
      drop_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_func_q  <= 3'd0;
      mem_wdata_q <= 32'd0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      drop_q      <= drop_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_func_q  <= mem_func_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_func  = mem_func_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// contention and reset-mid-access sequences.
module tb_mem_arbiter;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [2:0]  d_func;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        d_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_func;
    logic [31:0] mem_wdata;
    logic        busy;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst, if_req, if_flush, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [2:0]  d_func;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_func;

  int check_cnt = 0;
  int pass_cnt  = 0;
  vec_t vecs[$];

  localparam logic [31:0] IR = 32'h0050_0093;

  mem_arbiter #(.STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_func(d_func), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_func(mem_func),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic in_t ii(logic r, logic ir, logic [31:0] ia, logic fl, logic dr,
                             logic dwe, logic [31:0] da, logic [2:0] df,
                             logic [31:0] dw, logic [31:0] mr, logic rdy);
    ii = '{r, ir, ia, fl, dr, dwe, da, df, dw, mr, rdy};
  endfunction

  function automatic out_t oo(logic ig, logic dg, logic irv, logic [31:0] ird, logic drv,
                              logic [31:0] drd, logic en, logic we, logic [31:0] a,
                              logic [2:0] f, logic [31:0] wd, logic b);
    oo = '{ig, dg, irv, ird, drv, drd, en, we, a, f, wd, b};
  endfunction

  function automatic out_t sampleOutputs();
    sampleOutputs = '{if_gnt, d_gnt, if_rvalid, if_rdata, d_rvalid, d_rdata,
                      mem_en, mem_we, mem_addr, mem_func, mem_wdata, busy};
  endfunction

  task automatic addVec(input string n, input in_t i, input out_t e);
    vec_t v;
    v.name = n;
    v.i    = i;
    v.e    = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input in_t i);
    rst       = i.rst;
    if_req    = i.if_req;
    if_addr   = i.if_addr;
    if_flush  = i.if_flush;
    d_req     = i.d_req;
    d_we      = i.d_we;
    d_addr    = i.d_addr;
    d_func    = i.d_func;
    d_wdata   = i.d_wdata;
    mem_rdata = i.mem_rdata;
    mem_ready = i.mem_ready;
  endtask

  task automatic checkOutput(input string n, input out_t act, input out_t exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic checkBit(input string n, input logic act, input logic exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %b expected %b", n, act, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  int   order[$];
  int   exp_order[5] = '{0, 0, 0, 1, 0};
  out_t zero_out = '0;

  initial begin
    // Basic reset, fetch, store, back-to-back loads, flush, flush ignored on data
    addVec("rst_grants",  ii(1,1,32'h10,0,1,0,0,0,0,0,0),                 oo(0,0,0,0,0,0,0,0,0,0,0,0));
    addVec("f_gnt",       ii(0,1,32'h10,0,0,0,0,0,0,0,0),                 oo(1,0,0,0,0,0,0,0,0,0,0,0));
    addVec("f_busy1",     ii(0,0,0,0,0,0,0,0,0,0,0),                       oo(0,0,0,0,0,0,1,0,32'h10,3'b010,0,1));
    addVec("f_busy2",     ii(0,0,0,0,0,0,0,0,0,IR,1),                      oo(0,0,0,0,0,0,1,0,32'h10,3'b010,0,1));
    addVec("f_rvalid",    ii(0,0,0,0,0,0,0,0,0,0,0),                       oo(0,0,1,IR,0,0,0,0,32'h10,3'b010,0,0));
    addVec("st_gnt",      ii(0,0,0,0,1,1,32'h44,3'b000,32'hAB,0,0),       oo(0,1,0,IR,0,0,0,0,32'h10,3'b010,0,0));
    addVec("st_busy",     ii(0,0,0,0,0,0,0,0,0,32'hDEADBEEF,1),            oo(0,0,0,IR,0,0,1,1,32'h44,3'b000,32'hAB,1));
    addVec("st_rvalid",   ii(0,0,0,0,0,0,0,0,0,32'h1234,1),                oo(0,0,0,IR,1,0,0,1,32'h44,3'b000,32'hAB,0));
    addVec("idle_ready",  ii(0,0,0,0,0,0,0,0,0,0,0),                       oo(0,0,0,IR,0,0,0,1,32'h44,3'b000,32'hAB,0));
    addVec("b2b_gnt1",    ii(0,0,0,0,1,0,32'h100,3'b010,0,0,0),           oo(0,1,0,IR,0,0,0,1,32'h44,3'b000,32'hAB,0));
    addVec("b2b_busy1",   ii(0,0,0,0,1,0,32'h104,3'b010,0,32'h11111111,1), oo(0,0,0,IR,0,0,1,0,32'h100,3'b010,0,1));
    addVec("b2b_gnt2",    ii(0,0,0,0,1,0,32'h104,3'b010,0,0,0),           oo(0,1,0,IR,1,32'h11111111,0,0,32'h100,3'b010,0,0));
    addVec("b2b_busy2",   ii(0,0,0,0,0,0,0,0,0,32'h22222222,1),            oo(0,0,0,IR,0,32'h11111111,1,0,32'h104,3'b010,0,1));
    addVec("b2b_rvalid2", ii(0,0,0,0,0,0,0,0,0,0,0),                       oo(0,0,0,IR,1,32'h22222222,0,0,32'h104,3'b010,0,0));
    addVec("fl_gnt",      ii(0,1,32'h20,0,0,0,0,0,0,0,0),                 oo(1,0,0,IR,0,32'h22222222,0,0,32'h104,3'b010,0,0));
    addVec("fl_ready",    ii(0,0,0,1,0,0,0,0,0,32'hCAFEF00D,1),            oo(0,0,0,IR,0,32'h22222222,1,0,32'h20,3'b010,0,1));
    addVec("fl_regnt",    ii(0,1,32'h24,0,0,0,0,0,0,0,0),                 oo(1,0,0,IR,0,32'h22222222,0,0,32'h20,3'b010,0,0));
    addVec("fl_busy",     ii(0,0,0,0,0,0,0,0,0,32'h13,1),                  oo(0,0,0,IR,0,32'h22222222,1,0,32'h24,3'b010,0,1));
    addVec("fl_rvalid",   ii(0,0,0,0,0,0,0,0,0,0,0),                       oo(0,0,1,32'h13,0,32'h22222222,0,0,32'h24,3'b010,0,0));
    addVec("dfl_gnt",     ii(0,0,0,1,1,0,32'h200,3'b100,32'h55,0,0),      oo(0,1,0,32'h13,0,32'h22222222,0,0,32'h24,3'b010,0,0));
    addVec("dfl_busy",    ii(0,0,0,1,0,0,0,0,0,32'h77,1),                  oo(0,0,0,32'h13,0,32'h22222222,1,0,32'h200,3'b100,32'h55,1));
    addVec("dfl_rvalid",  ii(0,0,0,0,0,0,0,0,0,0,0),                       oo(0,0,0,32'h13,1,32'h77,0,0,32'h200,3'b100,32'h55,0));
    addVec("efl_gnt",     ii(0,1,32'h30,0,0,0,0,0,0,0,0),                 oo(1,0,0,32'h13,0,32'h77,0,0,32'h200,3'b100,32'h55,0));
    addVec("efl_flush",   ii(0,0,0,1,0,0,0,0,0,0,0),                       oo(0,0,0,32'h13,0,32'h77,1,0,32'h30,3'b010,0,1));
    addVec("efl_ready",   ii(0,0,0,0,0,0,0,0,0,32'h99,1),                  oo(0,0,0,32'h13,0,32'h77,1,0,32'h30,3'b010,0,1));
    addVec("efl_none",    ii(0,0,0,0,0,0,0,0,0,0,0),                       oo(0,0,0,32'h13,0,32'h77,0,0,32'h30,3'b010,0,0));

    applyStimulus(ii(1,0,0,0,0,0,0,0,0,0,0));
    nextCycle();
    nextCycle();

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].i);
      @(negedge clk);
      checkOutput(vecs[k].name, sampleOutputs(), vecs[k].e);
      nextCycle();
    end

    // Contention with mem_ready held high throughout: expect D, D, D, IF, D
    applyStimulus(ii(1,0,0,0,0,0,0,0,0,0,0));
    nextCycle();
    applyStimulus(ii(0,1,32'h40,0,1,0,32'h80,3'b010,0,32'h5A5A5A5A,1));
    for (int c = 0; c < 30 && order.size() < 5; c++) begin
      @(negedge clk);
      checkBit("gnt_exclusive", (if_gnt && d_gnt) || (busy && (if_gnt || d_gnt)), 1'b0);
      if (if_gnt)     order.push_back(1);
      else if (d_gnt) order.push_back(0);
      nextCycle();
    end
    if (order.size() < 5) begin
      check_cnt++;
      $display("[TB] FAIL contention_timeout: got %0d grants expected 5", order.size());
    end
    for (int k = 0; k < 5; k++) begin
      if (k < order.size()) checkBit($sformatf("grant_order_%0d", k), order[k] != 0, exp_order[k] != 0);
    end

    // The fifth grant leaves a load in flight; reset it before completion
    applyStimulus(ii(1,0,0,0,0,0,0,0,0,32'h5A5A5A5A,0));
    @(negedge clk);
    checkBit("rst_busy_gnt", if_gnt | d_gnt, 1'b0);
    checkBit("rst_busy_state", busy, 1'b1);
    nextCycle();
    applyStimulus(ii(0,0,0,0,0,0,0,0,0,32'h5A5A5A5A,1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("after_rst_%0d", c), sampleOutputs(), zero_out);
      nextCycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
